gate_arbiter: RTL and testbench

GATE_ARBITER -- requirements
Module: gate_arbiter

---
 rtl/gate_arbiter.sv | 165 ++++++++++++++++
 tb/tb_gate_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_arbiter.sv
// Parking-gate arbiter: grants the arm to one lane at a time and counts vehicles inside.
// Optional open-gate timeout is built in when the macro GATE_TIMEOUT_EN is defined.
module gate_arbiter #(
    parameter int unsigned CAPACIDAD = 10,
    parameter int unsigned TIMEOUT   = 15
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req_ent,
    input  logic       auth_ent,
    input  logic       req_sal,
    input  logic       auth_sal,
    input  logic       pas,
    output logic       gnt_ent,
    output logic       gnt_sal,
    output logic       aguja,
    output logic       alarma,
    output logic       lleno,
    output logic [3:0] ocupacion
);

    typedef enum logic [2:0] {
        StIdle,
        StOpenEnt,
        StOpenSal,
        StClearEnt,
        StClearSal
    } state_e;

    localparam logic [3:0] Cap = 4'(CAPACIDAD);

    if (CAPACIDAD == 0 || CAPACIDAD > 15) begin : g_bad_capacidad
        $error("gate_arbiter: CAPACIDAD must be in 1..15");
    end
    if (TIMEOUT < 2 || TIMEOUT > 15) begin : g_bad_timeout
        $error("gate_arbiter: TIMEOUT must be in 2..15");
    end

    state_e     state_q;
    logic       prio_q;
    logic       pas_q;
    logic       gnt_ent_q;
    logic       gnt_sal_q;
    logic       aguja_q;
    logic       alarma_q;
    logic [3:0] ocup_q;
    logic       full;
    logic       elig_ent;
    logic       elig_sal;
    logic       pick_ent;

`ifdef GATE_TIMEOUT_EN
    localparam logic [3:0] TmoLast = 4'(TIMEOUT - 1);
    logic [3:0] timer_q;
`endif

    assign full     = (ocup_q == Cap);
    assign elig_ent = req_ent & auth_ent & ~full;
    assign elig_sal = req_sal & auth_sal & (ocup_q != 4'd0);
    // Entry wins when it is the only candidate or when the round-robin pointer favours it.
    assign pick_ent = elig_ent & (~elig_sal | ~prio_q);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StIdle;
            prio_q    <= 1'b0;
            pas_q     <= 1'b0;
            gnt_ent_q <= 1'b0;
            gnt_sal_q <= 1'b0;
            aguja_q   <= 1'b0;
            alarma_q  <= 1'b0;
            ocup_q    <= 4'd0;
`ifdef GATE_TIMEOUT_EN
            timer_q   <= 4'd0;
`endif
        end else begin
            pas_q    <= pas;
            alarma_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // A vehicle under the arm with no grant is a passage violation.
                    if (pas && !pas_q) begin
                        alarma_q <= 1'b1;
                    end
`ifdef GATE_TIMEOUT_EN
                    timer_q <= 4'd0;
`endif
                    if (pick_ent) begin
                        state_q   <= StOpenEnt;
                        gnt_ent_q <= 1'b1;
                        aguja_q   <= 1'b1;
                    end else if (elig_sal) begin
                        state_q   <= StOpenSal;
                        gnt_sal_q <= 1'b1;
                        aguja_q   <= 1'b1;
                    end
                end
                StOpenEnt: begin
                    if (pas) begin
                        state_q <= StClearEnt;
`ifdef GATE_TIMEOUT_EN
                    end else if (timer_q == TmoLast) begin
                        state_q   <= StIdle;
                        gnt_ent_q <= 1'b0;
                        aguja_q   <= 1'b0;
                        alarma_q  <= 1'b1;
                    end else begin
                        timer_q <= timer_q + 4'd1;
`endif
                    end
                end
                StOpenSal: begin
                    if (pas) begin
                        state_q <= StClearSal;
`ifdef GATE_TIMEOUT_EN
                    end else if (timer_q == TmoLast) begin
                        state_q   <= StIdle;
                        gnt_sal_q <= 1'b0;
                        aguja_q   <= 1'b0;
                        alarma_q  <= 1'b1;
                    end else begin
                        timer_q <= timer_q + 4'd1;
`endif
                    end
                end
                StClearEnt: begin
                    if (!pas) begin
                        state_q   <= StIdle;
                        gnt_ent_q <= 1'b0;
                        aguja_q   <= 1'b0;
                        prio_q    <= 1'b1;
                        if (ocup_q < Cap) begin
                            ocup_q <= ocup_q + 4'd1;
                        end
                    end
                end
                StClearSal: begin
                    if (!pas) begin
                        state_q   <= StIdle;
                        gnt_sal_q <= 1'b0;
                        aguja_q   <= 1'b0;
                        prio_q    <= 1'b0;
                        if (ocup_q != 4'd0) begin
                            ocup_q <= ocup_q - 4'd1;
                        end
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    gnt_ent_q <= 1'b0;
                    gnt_sal_q <= 1'b0;
                    aguja_q   <= 1'b0;
                end
            endcase
        end
    end

    assign gnt_ent   = gnt_ent_q;
    assign gnt_sal   = gnt_sal_q;
    assign aguja     = aguja_q;
    assign alarma    = alarma_q;
    assign lleno     = full;
    assign ocupacion = ocup_q;

endmodule

// File: tb/tb_gate_arbiter.sv
// Bench for gate_arbiter: directed scenarios then random traffic, all checked against a
// lane/occupancy reference model. Timeout scenario is included when GATE_TIMEOUT_EN is defined.
module tb_gate_arbiter;

    localparam int CAP = 2;
    localparam int TMO = 15;

    logic       clock;
    logic       reset;
    logic       req_ent;
    logic       auth_ent;
    logic       req_sal;
    logic       auth_sal;
    logic       pas;
    logic       gnt_ent;
    logic       gnt_sal;
    logic       aguja;
    logic       alarma;
    logic       lleno;
    logic [3:0] ocupacion;

    int vectors;
    int miscompares;

    // Reference model: which lane holds the gate (-1 none), whether its vehicle has reached
    // the arm, cycles waited, vehicles inside, next preferred lane.
    int m_lane;
    bit m_car;
    int m_wait;
    int m_occ;
    int m_turn;
    bit m_alarm;
    bit m_pas_prev;

    gate_arbiter #(
        .CAPACIDAD(CAP),
        .TIMEOUT  (TMO)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .req_ent  (req_ent),
        .auth_ent (auth_ent),
        .req_sal  (req_sal),
        .auth_sal (auth_sal),
        .pas      (pas),
        .gnt_ent  (gnt_ent),
        .gnt_sal  (gnt_sal),
        .aguja    (aguja),
        .alarma   (alarma),
        .lleno    (lleno),
        .ocupacion(ocupacion)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit prev;
        bit e;
        bit s;
        m_alarm = 1'b0;
        if (reset) begin
            m_lane     = -1;
            m_car      = 1'b0;
            m_wait     = 0;
            m_occ      = 0;
            m_turn     = 0;
            m_pas_prev = 1'b0;
            return;
        end
        prev       = m_pas_prev;
        m_pas_prev = pas;
        if (m_lane < 0) begin
            if (pas && !prev) m_alarm = 1'b1;
            e = req_ent && auth_ent && (m_occ != CAP);
            s = req_sal && auth_sal && (m_occ != 0);
            if (e && s) m_lane = m_turn;
            else if (e) m_lane = 0;
            else if (s) m_lane = 1;
            m_wait = 0;
            m_car  = 1'b0;
        end else if (!m_car) begin
            if (pas) m_car = 1'b1;
`ifdef GATE_TIMEOUT_EN
            else if (m_wait == TMO - 1) begin
                m_lane  = -1;
                m_alarm = 1'b1;
            end
`endif
            else m_wait++;
        end else if (!pas) begin
            if (m_lane == 0) m_occ = (m_occ < CAP) ? m_occ + 1 : m_occ;
            else m_occ = (m_occ > 0) ? m_occ - 1 : m_occ;
            m_turn = (m_lane == 0) ? 1 : 0;
            m_lane = -1;
            m_car  = 1'b0;
        end
    endtask

    task automatic check_model();
        chk("gnt_ent", gnt_ent, 4'(m_lane == 0));
        chk("gnt_sal", gnt_sal, 4'(m_lane == 1));
        chk("aguja", aguja, 4'(m_lane >= 0));
        chk("alarma", alarma, 4'(m_alarm));
        chk("lleno", lleno, 4'(m_occ == CAP));
        chk("ocupacion", ocupacion, 4'(m_occ));
    endtask

    task automatic cyc(input logic r, input logic re, input logic ae, input logic rs,
                       input logic as_v, input logic p);
        reset    = r;
        req_ent  = re;
        auth_ent = ae;
        req_sal  = rs;
        auth_sal = as_v;
        pas      = p;
        @(posedge clock);
        model_step();
        #1;
        check_model();
    endtask

    initial begin
        logic r, re, ae, rs, as_v, p;
        vectors     = 0;
        miscompares = 0;
        m_lane      = -1;
        m_car       = 1'b0;
        m_wait      = 0;
        m_occ       = 0;
        m_turn      = 0;
        m_alarm     = 1'b0;
        m_pas_prev  = 1'b0;

        // Reset state
        cyc(1, 1, 1, 1, 1, 1);
        cyc(1, 0, 0, 0, 0, 0);
        chk("rst_aguja", aguja, 4'd0);
        chk("rst_gnt_ent", gnt_ent, 4'd0);
        chk("rst_alarma", alarma, 4'd0);
        chk("rst_ocup", ocupacion, 4'd0);
        cyc(0, 0, 0, 0, 0, 0);

        // Single entry: grant next edge, held after req drops, count on pas fall
        cyc(0, 1, 1, 0, 0, 0);
        chk("ent_gnt", gnt_ent, 4'd1);
        chk("ent_aguja", aguja, 4'd1);
        cyc(0, 0, 0, 0, 0, 0);
        chk("ent_hold", gnt_ent, 4'd1);
        repeat (3) cyc(0, 0, 0, 0, 0, 1);
        chk("ent_clear_ocup", ocupacion, 4'd0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("ent_done_ocup", ocupacion, 4'd1);
        chk("ent_done_aguja", aguja, 4'd0);

        // Second entry fills the lot
        cyc(0, 1, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0);
        chk("full_lleno", lleno, 4'd1);
        cyc(0, 1, 1, 0, 0, 0);
        chk("full_no_gnt", gnt_ent, 4'd0);
        chk("full_aguja", aguja, 4'd0);

        // Exit frees a slot
        cyc(0, 0, 0, 1, 1, 0);
        chk("sal_gnt", gnt_sal, 4'd1);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0);
        chk("sal_ocup", ocupacion, 4'd1);
        chk("sal_lleno", lleno, 4'd0);

        // Both lanes eligible with prio on entry: entry, then exit, then entry again
        cyc(0, 1, 1, 1, 1, 0);
        chk("rr1_ent", gnt_ent, 4'd1);
        chk("rr1_sal", gnt_sal, 4'd0);
        cyc(0, 1, 1, 1, 1, 1);
        cyc(0, 1, 1, 1, 1, 0);
        cyc(0, 1, 1, 1, 1, 0);
        chk("rr2_sal", gnt_sal, 4'd1);
        cyc(0, 1, 1, 1, 1, 1);
        cyc(0, 0, 0, 0, 0, 0);
        chk("rr2_ocup", ocupacion, 4'd1);
        cyc(0, 1, 1, 1, 1, 0);
        chk("rr3_ent", gnt_ent, 4'd1);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 0);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0);

        // Passage with no grant raises a one-cycle alarm
        cyc(0, 0, 0, 0, 0, 1);
        chk("viol_alarma", alarma, 4'd1);
        chk("viol_aguja", aguja, 4'd0);
        cyc(0, 0, 0, 0, 0, 1);
        chk("viol_pulse", alarma, 4'd0);
        cyc(0, 0, 0, 0, 0, 0);

`ifdef GATE_TIMEOUT_EN
        cyc(0, 1, 1, 0, 0, 0);
        repeat (TMO - 1) cyc(0, 0, 0, 0, 0, 0);
        chk("tmo_still_open", aguja, 4'd1);
        cyc(0, 0, 0, 0, 0, 0);
        chk("tmo_aguja", aguja, 4'd0);
        chk("tmo_alarma", alarma, 4'd1);
        chk("tmo_ocup", ocupacion, 4'd1);
        cyc(0, 0, 0, 0, 0, 0);
`endif

        // Reset while an exiting vehicle is under the arm
        cyc(0, 0, 0, 1, 1, 0);
        cyc(0, 0, 0, 1, 1, 1);
        chk("clr_sal_gnt", gnt_sal, 4'd1);
        cyc(1, 1, 1, 1, 1, 1);
        chk("mid_rst_aguja", aguja, 4'd0);
        chk("mid_rst_gnt", gnt_sal, 4'd0);
        chk("mid_rst_ocup", ocupacion, 4'd0);
        cyc(0, 0, 0, 0, 0, 0);

        // Empty lot refuses exit
        cyc(0, 0, 0, 1, 1, 0);
        chk("empty_gnt_sal", gnt_sal, 4'd0);
        chk("empty_aguja", aguja, 4'd0);

        // Random traffic; pas toggles occasionally so vehicles linger under the arm
        p = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            r    = ($urandom_range(0, 299) == 0);
            re   = ($urandom_range(0, 2) != 0);
            ae   = ($urandom_range(0, 3) != 0);
            rs   = ($urandom_range(0, 2) != 0);
            as_v = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) p = ~p;
            cyc(r, re, ae, rs, as_v, p);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
